iic_eeprom_slave: RTL and testbench

- Synthesizable I2C target that emulates a 24Cxx-style EEPROM with a 2-byte word address. It responds to the existing IIC master path (device address, word address high and low, then write or read burst).
- Used as an on-chip loopback partner for bring-up and as a bench model for the master driver.
- Oversamples SCL/SDA on the system clock; storage is an internal byte RAM.

---
 rtl/iic_eeprom_slave.sv | 197 +++++++++++++++++++
 tb/tb_iic_eeprom_slave.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iic_eeprom_slave.sv
// I2C target emulating a 24Cxx EEPROM with a 2-byte word address and an internal byte RAM.
// Optional write protect input i_wp is enabled by defining IIC_WRITE_PROTECT_EN.
`timescale 1ns/1ps
module iic_eeprom_slave #(
  parameter logic [3:0]  P_DEV_TYPE  = 4'b1010,
  parameter logic [2:0]  P_CHIP_ADDR = 3'b011,
  parameter int unsigned P_MEM_AW    = 8,
  parameter int unsigned P_PAGE_AW   = 3
) (
  input  logic       i_clk,
  input  logic       i_rst,
`ifdef IIC_WRITE_PROTECT_EN
  input  logic       i_wp,
`endif
  input  logic       i_iic_scl,
  inout  wire        io_iic_sda,
  output logic [7:0] o_wr_byte,
  output logic       o_wr_valid,
  output logic       o_busy
);

  localparam int unsigned LP_DEPTH = 1 << P_MEM_AW;

  typedef enum logic [3:0] {
    S_IDLE, S_DEV, S_DEV_ACK, S_AH, S_AH_ACK, S_AL, S_AL_ACK,
    S_WR, S_WR_ACK, S_RD, S_RD_ACK
  } state_t;

  state_t                r_state;
  logic                  r_scl_s1, r_scl_s2, r_scl_d;
  logic                  r_sda_s1, r_sda_s2, r_sda_d;
  logic [2:0]            r_bit_cnt;
  logic [7:0]            r_shift;
  logic [7:0]            r_addr_hi;
  logic [P_MEM_AW-1:0]   r_ptr;
  logic                  r_rnw;
  logic                  r_sda_low;
  logic [7:0]            r_wr_byte;
  logic                  r_wr_valid;
  logic [7:0]            r_mem [LP_DEPTH];

  logic                  w_scl_rise, w_scl_fall, w_start, w_stop;
  logic                  w_wp, w_mem_we;
  logic [7:0]            w_byte, w_rd_byte;

  // Oversampling synchronizers with one history flop; bus idles high
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      {r_scl_s1, r_scl_s2, r_scl_d} <= 3'b111;
      {r_sda_s1, r_sda_s2, r_sda_d} <= 3'b111;
    end else begin
      {r_scl_s1, r_scl_s2, r_scl_d} <= {i_iic_scl, r_scl_s1, r_scl_s2};
      {r_sda_s1, r_sda_s2, r_sda_d} <= {io_iic_sda, r_sda_s1, r_sda_s2};
    end
  end

`ifdef IIC_WRITE_PROTECT_EN
  logic r_wp_s1, r_wp_s2;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) {r_wp_s1, r_wp_s2} <= 2'b00;
    else       {r_wp_s1, r_wp_s2} <= {i_wp, r_wp_s1};
  end
  assign w_wp = r_wp_s2;
`else
  assign w_wp = 1'b0;
`endif

  assign w_scl_rise = r_scl_s2 & ~r_scl_d;
  assign w_scl_fall = ~r_scl_s2 & r_scl_d;
  assign w_start    = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
  assign w_stop     = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;
  assign w_byte     = {r_shift[6:0], r_sda_s2};
  assign w_rd_byte  = r_mem[r_ptr];
  assign w_mem_we   = (r_state == S_WR) & w_scl_rise & (r_bit_cnt == 3'd7)
                    & ~w_start & ~w_stop & ~w_wp;

  // Storage is deliberately left out of reset
  always_ff @(posedge i_clk) begin
    if (w_mem_we) r_mem[r_ptr] <= w_byte;
  end

  // Protocol FSM: data sampled on SCL rise, SDA drive changed only on SCL fall
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= 3'd0;
      r_shift    <= 8'd0;
      r_addr_hi  <= 8'd0;
      r_ptr      <= '0;
      r_rnw      <= 1'b0;
      r_sda_low  <= 1'b0;
      r_wr_byte  <= 8'd0;
      r_wr_valid <= 1'b0;
    end else begin
      r_wr_valid <= 1'b0;
      if (w_stop) begin
        r_state   <= S_IDLE;
        r_bit_cnt <= 3'd0;
        r_sda_low <= 1'b0;
      end else if (w_start) begin
        r_state   <= S_DEV;
        r_bit_cnt <= 3'd0;
        r_sda_low <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: ;
          S_DEV, S_AH, S_AL, S_WR: begin
            if (w_scl_fall) begin
              r_sda_low <= 1'b0;
            end else if (w_scl_rise) begin
              r_shift   <= w_byte;
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                case (r_state)
                  S_DEV: begin
                    if (w_byte[7:1] == {P_DEV_TYPE, P_CHIP_ADDR}) begin
                      r_rnw   <= w_byte[0];
                      r_state <= S_DEV_ACK;
                    end else begin
                      r_state <= S_IDLE;
                    end
                  end
                  S_AH: begin
                    r_addr_hi <= w_byte;
                    r_state   <= S_AH_ACK;
                  end
                  S_AL: begin
                    r_ptr   <= P_MEM_AW'({r_addr_hi, w_byte});
                    r_state <= S_AL_ACK;
                  end
                  default: begin
                    if (!w_wp) begin
                      r_wr_byte  <= w_byte;
                      r_wr_valid <= 1'b1;
                    end
                    r_ptr   <= {r_ptr[P_MEM_AW-1:P_PAGE_AW],
                                r_ptr[P_PAGE_AW-1:0] + P_PAGE_AW'(1)};
                    r_state <= S_WR_ACK;
                  end
                endcase
              end
            end
          end
          S_DEV_ACK, S_AH_ACK, S_AL_ACK, S_WR_ACK: begin
            if (w_scl_fall) begin
              r_sda_low <= 1'b1;
            end else if (w_scl_rise) begin
              r_bit_cnt <= 3'd0;
              case (r_state)
                S_DEV_ACK: begin
                  if (r_rnw) begin
                    r_shift <= w_rd_byte;
                    r_ptr   <= r_ptr + P_MEM_AW'(1);
                    r_state <= S_RD;
                  end else begin
                    r_state <= S_AH;
                  end
                end
                S_AH_ACK: r_state <= S_AL;
                default:  r_state <= S_WR;
              endcase
            end
          end
          S_RD: begin
            if (w_scl_fall) begin
              r_sda_low <= ~r_shift[3'd7 - r_bit_cnt];
            end else if (w_scl_rise) begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) r_state <= S_RD_ACK;
            end
          end
          S_RD_ACK: begin
            if (w_scl_fall) begin
              r_sda_low <= 1'b0;
            end else if (w_scl_rise) begin
              r_bit_cnt <= 3'd0;
              if (!r_sda_s2) begin
                r_shift <= w_rd_byte;
                r_ptr   <= r_ptr + P_MEM_AW'(1);
                r_state <= S_RD;
              end else begin
                r_state <= S_IDLE;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign io_iic_sda = r_sda_low ? 1'b0 : 1'bz;
  assign o_wr_byte  = r_wr_byte;
  assign o_wr_valid = r_wr_valid;
  assign o_busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_iic_eeprom_slave.sv
// Bench for iic_eeprom_slave: bit-banged I2C master, shadow memory model and write-strobe scoreboard.
`timescale 1ns/1ps
module tb_iic_eeprom_slave;

  localparam int unsigned LP_Q = 50;

  logic       clk = 1'b0;
  logic       rst;
  logic       m_scl;
  logic       m_sda_low;
  wire        w_sda;
  logic [7:0] wr_byte;
  logic       wr_valid;
  logic       busy;
`ifdef IIC_WRITE_PROTECT_EN
  logic       wp = 1'b0;
`endif

  always #5 clk = ~clk;

  assign w_sda = m_sda_low ? 1'b0 : 1'bz;
  pullup (w_sda);

  iic_eeprom_slave dut (
    .i_clk      (clk),
    .i_rst      (rst),
`ifdef IIC_WRITE_PROTECT_EN
    .i_wp       (wp),
`endif
    .i_iic_scl  (m_scl),
    .io_iic_sda (w_sda),
    .o_wr_byte  (wr_byte),
    .o_wr_valid (wr_valid),
    .o_busy     (busy)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_wr_q[$];
  logic [7:0] exp_rd_q[$];
  logic [7:0] buf_q[$];
  logic [7:0] exp_mem [256];
  logic [7:0] tb_ptr = 8'd0;
  logic       watch = 1'b0;
  int         drv_low_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Write strobe scoreboard and watch for any low SDA the master did not cause
  always @(negedge clk) begin
    if (wr_valid) begin
      if (exp_wr_q.size() == 0) chk("wr_unexpected_strobe", 32'(wr_valid), 32'd0);
      else                      chk("wr_byte", 32'(wr_byte), 32'(exp_wr_q.pop_front()));
    end
    if (watch && !m_sda_low && w_sda === 1'b0) drv_low_cnt++;
  end

  task automatic i2c_start;
    m_sda_low = 1'b0; #LP_Q;
    m_scl     = 1'b1; #LP_Q;
    m_sda_low = 1'b1; #LP_Q;
    m_scl     = 1'b0; #LP_Q;
  endtask

  task automatic i2c_stop;
    m_sda_low = 1'b1; #LP_Q;
    m_scl     = 1'b1; #LP_Q;
    m_sda_low = 1'b0; #(2*LP_Q);
  endtask

  task automatic write_bit(input logic b);
    m_sda_low = ~b; #LP_Q;
    m_scl     = 1'b1; #(2*LP_Q);
    m_scl     = 1'b0; #LP_Q;
  endtask

  task automatic read_bit(output logic b);
    m_sda_low = 1'b0; #LP_Q;
    m_scl     = 1'b1; #LP_Q;
    b = (w_sda === 1'b0) ? 1'b0 : 1'b1;
    #LP_Q;
    m_scl     = 1'b0; #LP_Q;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(b);
    ack = ~b;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(~mack);
  endtask

  task automatic send(input logic [7:0] d, input string tag);
    logic ack;
    write_byte(d, ack);
    chk(tag, 32'(ack), 32'd1);
  endtask

  task automatic set_addr(input logic [15:0] a);
    i2c_start;
    send(8'hA6, "ack_dev_w");
    send(a[15:8], "ack_addr_hi");
    send(a[7:0], "ack_addr_lo");
    tb_ptr = a[7:0];
  endtask

  // Writes buf_q starting at a; pointer wraps inside the 8-byte page
  task automatic wr_bytes(input logic [15:0] a, input logic prot);
    set_addr(a);
    foreach (buf_q[i]) begin
      if (!prot) begin
        exp_wr_q.push_back(buf_q[i]);
        exp_mem[tb_ptr] = buf_q[i];
      end
      send(buf_q[i], "ack_data");
      tb_ptr = {tb_ptr[7:3], tb_ptr[2:0] + 3'd1};
    end
    i2c_stop;
  endtask

  task automatic read_n(input int n);
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      exp_rd_q.push_back(exp_mem[tb_ptr]);
      tb_ptr = tb_ptr + 8'd1;
      read_byte(i != n - 1, d);
      chk("rd_byte", 32'(d), 32'(exp_rd_q.pop_front()));
    end
    i2c_stop;
  endtask

  task automatic rand_read(input logic [15:0] a, input int n);
    set_addr(a);
    i2c_start;
    send(8'hA7, "ack_dev_r");
    read_n(n);
  endtask

  initial begin
    logic ack;
    rst = 1'b1; m_scl = 1'b1; m_sda_low = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr_valid", 32'(wr_valid), 32'd0);
    chk("rst_wr_byte", 32'(wr_byte), 32'd0);
    chk("rst_sda_released", 32'(w_sda), 32'd1);
    rst = 1'b0;
    #(4*LP_Q);

    // Page write 0..7 at 0x0000
    buf_q = {8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    wr_bytes(16'h0000, 1'b0);
    chk("busy_after_stop", 32'(busy), 32'd0);

    rand_read(16'h0000, 8);
    chk("busy_after_read", 32'(busy), 32'd0);

    // Page wrap and full-depth read wrap
    buf_q = {8'hAA, 8'hBB, 8'hCC};
    wr_bytes(16'h0006, 1'b0);
    buf_q = {8'h5A};
    wr_bytes(16'h00FF, 1'b0);
    rand_read(16'h0006, 2);
    rand_read(16'h0000, 1);
    rand_read(16'h00FF, 2);

    // Current-address read continues from the persisted pointer
    i2c_start;
    send(8'hA7, "ack_dev_cur");
    read_n(1);

    // Wrong device address is ignored
    drv_low_cnt = 0;
    watch = 1'b1;
    i2c_start;
    write_byte(8'hA0, ack);
    chk("wrong_addr_nack", 32'(ack), 32'd0);
    chk("wrong_addr_idle", 32'(busy), 32'd0);
    i2c_stop;
    watch = 1'b0;
    chk("wrong_addr_no_drive", 32'(drv_low_cnt), 32'd0);
    i2c_start;
    send(8'hA6, "ack_after_wrong");
    chk("busy_in_xfer", 32'(busy), 32'd1);
    i2c_stop;

    // Abort after 4 data bits: nothing stored
    set_addr(16'h0002);
    for (int i = 0; i < 4; i++) write_bit(1'b1);
    i2c_stop;
    chk("abort_idle", 32'(busy), 32'd0);
    rand_read(16'h0002, 1);

    // Reset asserted while the target drives a 0 bit
    set_addr(16'h0002);
    i2c_start;
    send(8'hA7, "ack_dev_r_rst");
    chk("rd_drive_low", 32'(w_sda), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_read_release", 32'(w_sda), 32'd1);
    chk("rst_mid_read_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    m_scl = 1'b1;
    #(4*LP_Q);
    rand_read(16'h0000, 3);

`ifdef IIC_WRITE_PROTECT_EN
    buf_q = {8'h33};
    wr_bytes(16'h0010, 1'b0);
    wp = 1'b1;
    #(2*LP_Q);
    buf_q = {8'h55};
    wr_bytes(16'h0010, 1'b1);
    wp = 1'b0;
    #(2*LP_Q);
    rand_read(16'h0010, 1);
`endif

    #(4*LP_Q);
    chk("wr_q_empty", 32'(exp_wr_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
